pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 62 ++++++
 tb/tb_pipe_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller producing stall/flush/redirect with zero-cycle response.
module pipe_ctrl #(
  parameter int CNT_W = 16,
  parameter int TGT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_wait_req,
  input  logic             ex_busy_req,
  input  logic             id_load_use_req,
  input  logic             ex_branch_taken,
  input  logic [TGT_W-1:0] ex_branch_target,
  output logic [5:0]       stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             new_pc_valid,
  output logic [TGT_W-1:0] new_pc,
  output logic [2:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    EX_BUSY  = 3'd2,
    LOAD_USE = 3'd3,
    REDIRECT = 3'd4
  } state_t;
  state_t state, next;
  logic pend_valid;
  logic [TGT_W-1:0] pend_target;
  logic hold, redir, load_use;
  always_comb begin
    hold = mem_wait_req | ex_busy_req;
    redir = !hold && (pend_valid || ex_branch_taken);
    load_use = !hold && !redir && id_load_use_req && state != LOAD_USE;
    next = mem_wait_req ? MEM_WAIT : ex_busy_req ? EX_BUSY : redir ? REDIRECT : load_use ? LOAD_USE : RUN;
    stall = rst ? 6'b000000 : mem_wait_req ? 6'b011111 : ex_busy_req ? 6'b001111 : load_use ? 6'b000111 : 6'b000000;
    flush_if_id = !rst && redir;
    flush_id_ex = !rst && (redir || load_use);
    new_pc_valid = !rst && redir;
    // A held redirect always takes precedence over a branch pulse arriving later.
    new_pc = !new_pc_valid ? '0 : pend_valid ? pend_target : ex_branch_target;
  end
  assign ctrl_state = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pend_valid <= 1'b0;
      pend_target <= '0;
      stall_cycles <= '0;
    end else begin
      state <= next;
      if (hold && ex_branch_taken && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_target <= ex_branch_target;
      end else if (redir) begin
        pend_valid <= 1'b0;
      end
      if (stall[0] && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: random + directed stimulus checked each cycle against a behavioural model.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1, mem = 1'b0, busy = 1'b0, lu = 1'b0, br = 1'b0;
  logic [31:0] tgt = '0;
  logic [5:0] stall, stall4;
  logic fi, fe, nv, fi4, fe4, nv4;
  logic [31:0] npc, npc4;
  logic [2:0] cst, cst4;
  logic [15:0] cnt;
  logic [3:0] cnt4;
  int vectors = 0, errs = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .mem_wait_req(mem), .ex_busy_req(busy), .id_load_use_req(lu),
    .ex_branch_taken(br), .ex_branch_target(tgt), .stall(stall), .flush_if_id(fi),
    .flush_id_ex(fe), .new_pc_valid(nv), .new_pc(npc), .ctrl_state(cst), .stall_cycles(cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mem_wait_req(mem), .ex_busy_req(busy), .id_load_use_req(lu),
    .ex_branch_taken(br), .ex_branch_target(tgt), .stall(stall4), .flush_if_id(fi4),
    .flush_id_ex(fe4), .new_pc_valid(nv4), .new_pc(npc4), .ctrl_state(cst4), .stall_cycles(cnt4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state names 0 RUN,1 MEM_WAIT,2 EX_BUSY,3 LOAD_USE,4 REDIRECT; pending target in a queue.
  int m_state = 0, m_cnt = 0, m_cnt4 = 0, nxt;
  logic [31:0] pq[$];
  logic [5:0] e_stall;
  logic e_fi, e_fe, e_nv;
  logic [31:0] e_pc;

  always @(negedge clk) begin
    e_stall = '0; e_fi = 0; e_fe = 0; e_nv = 0; e_pc = '0; nxt = 0;
    if (!rst) begin
      if (mem) begin e_stall = 6'b011111; nxt = 1; end
      else if (busy) begin e_stall = 6'b001111; nxt = 2; end
      else if (pq.size() != 0 || br) begin
        e_nv = 1; e_fi = 1; e_fe = 1; nxt = 4;
        e_pc = (pq.size() != 0) ? pq[0] : tgt;
      end else if (lu && m_state != 3) begin e_stall = 6'b000111; e_fe = 1; nxt = 3; end
    end
    chk("stall", 64'(stall), 64'(e_stall));
    chk("flush_if_id", 64'(fi), 64'(e_fi));
    chk("flush_id_ex", 64'(fe), 64'(e_fe));
    chk("new_pc_valid", 64'(nv), 64'(e_nv));
    chk("new_pc", 64'(npc), 64'(e_pc));
    chk("ctrl_state", 64'(cst), 64'(m_state));
    chk("stall_cycles", 64'(cnt), 64'(m_cnt));
    chk("stall_cycles4", 64'(cnt4), 64'(m_cnt4));
    chk("stall4", 64'(stall4), 64'(e_stall));
    if (rst) begin
      m_state = 0; m_cnt = 0; m_cnt4 = 0; pq.delete();
    end else begin
      m_state = nxt;
      if (e_stall[0]) begin
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        m_cnt4 = (m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4;
      end
      if (e_nv) pq.delete();
      else if ((mem || busy) && br && pq.size() == 0) pq.push_back(tgt);
    end
  end

  // Drive one cycle's inputs just after the rising edge; returns with outputs settled.
  task automatic drive(input logic r, m, e, l, b, input logic [31:0] t);
    @(posedge clk);
    #1;
    rst = r; mem = m; busy = e; lu = l; br = b; tgt = t;
    #2;
  endtask

  initial begin
    drive(1, 1, 1, 1, 1, 32'h1234);
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_nv", 64'(nv), 64'h0);
    chk("rst_npc", 64'(npc), 64'h0);
    // Load-use held two cycles: only the first stalls.
    drive(0, 0, 0, 1, 0, 0);
    chk("lu1_stall", 64'(stall), 64'h07);
    chk("lu1_fe", 64'(fe), 64'h1);
    drive(0, 0, 0, 1, 0, 0);
    chk("lu2_state", 64'(cst), 64'h3);
    chk("lu2_stall", 64'(stall), 64'h0);
    drive(0, 0, 0, 0, 0, 0);
    chk("lu_cnt", 64'(cnt), 64'h1);
    // Busy four cycles with a branch arriving mid-stall.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 1, 0, i == 2, (i == 2) ? 32'h80 : 32'h0);
      chk("busy_stall", 64'(stall), 64'h0f);
      chk("busy_nv", 64'(nv), 64'h0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("pend_nv", 64'(nv), 64'h1);
    chk("pend_pc", 64'(npc), 64'h80);
    chk("pend_fi", 64'(fi), 64'h1);
    chk("pend_fe", 64'(fe), 64'h1);
    // Memory wait and busy together, then busy alone.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 0);
      chk("mw_stall", 64'(stall), 64'h1f);
    end
    drive(0, 0, 1, 0, 0, 0);
    chk("mw_state", 64'(cst), 64'h1);
    chk("eb_stall", 64'(stall), 64'h0f);
    drive(0, 0, 0, 0, 0, 0);
    chk("eb_state", 64'(cst), 64'h2);
    // Branch beats a simultaneous load-use.
    drive(0, 0, 0, 1, 1, 32'h1000);
    chk("br_nv", 64'(nv), 64'h1);
    chk("br_pc", 64'(npc), 64'h1000);
    chk("br_stall", 64'(stall), 64'h0);
    drive(0, 0, 0, 0, 0, 0);
    chk("br_state", 64'(cst), 64'h4);
    // Reset discards a pending redirect.
    drive(0, 0, 1, 0, 1, 32'h44);
    drive(1, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rstpend_nv", 64'(nv), 64'h0);
    chk("rstpend_cnt", 64'(cnt), 64'h0);
    // Counter saturation on the 4-bit instance.
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("sat_cnt4", 64'(cnt4), 64'd15);
    chk("sat_cnt", 64'(cnt), 64'd20);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
